// File: rtl/inv_kaliski_shift.sv
// inv_kaliski_shift
//   Modular inverse with a selectable power-of-two factor:
//   R = X^-1 * 2^SH mod M, SH in 0..2N (larger requests are clamped to 2N).
//   A Kaliski almost-inverse loop produces X^-1 * 2^k mod M. A second loop
//   then halves or doubles modulo M until the exponent equals SH.
//   Inputs that have no inverse are flagged with err=1 and R=0.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   X, M, shift           operand, odd modulus, requested exponent
//                         (all sampled on accept)
//   req_valid, req_ready  request handshake; req_ready is high only in IDLE
//   abort                 cancels an operation in flight (ignored in IDLE/DONE)
//   busy                  operation in flight
//   R, err                result and error flag, valid while res_valid=1
//   res_valid, res_ready  result handshake; the result is held until accepted
//
// state | meaning
// IDLE  | waiting for a request
// CHECK | reject even/unit modulus, zero operand, operand >= modulus
// LOOP1 | Kaliski almost-inverse steps, k counts the steps
// FIX   | gcd test, convert r into X^-1 * 2^k mod M
// LOOP2 | move k towards SH one halving/doubling at a time
// DONE  | result presented until res_ready
module inv_kaliski_shift #(
  parameter int N  = 255,
  parameter int SW = $clog2(2*N+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  X,
  input  logic [N-1:0]  M,
  input  logic [SW-1:0] shift,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          abort,
  output logic          busy,
  output logic [N-1:0]  R,
  output logic          err,
  output logic          res_valid,
  input  logic          res_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_LOOP1, S_FIX, S_LOOP2, S_DONE
  } state_t;

  localparam logic [SW-1:0] SH_MAX = SW'(2*N);

  state_t        state_q, state_d;
  logic [N-1:0]  u_q, u_d, v_q, v_d, m_q, m_d, res_q, res_d;
  logic [N+1:0]  r_q, r_d, s_q, s_d;
  logic [SW-1:0] k_q, k_d, sh_q, sh_d;
  logic          err_q, err_d;

  logic [N+1:0]  m_ext, r_red, r_dbl, r_sum, s_dbl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      u_q     <= '0;
      v_q     <= '0;
      m_q     <= '0;
      r_q     <= '0;
      s_q     <= '0;
      k_q     <= '0;
      sh_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      m_q     <= m_d;
      r_q     <= r_d;
      s_q     <= s_d;
      k_q     <= k_d;
      sh_q    <= sh_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    v_d     = v_q;
    m_d     = m_q;
    r_d     = r_q;
    s_d     = s_q;
    k_d     = k_q;
    sh_d    = sh_q;
    res_d   = res_q;
    err_d   = err_q;

    m_ext = {2'b00, m_q};
    // r and s stay below 2M, so one conditional subtraction fully reduces r
    r_red = (r_q >= m_ext) ? (r_q - m_ext) : r_q;
    r_dbl = {r_q[N:0], 1'b0};
    s_dbl = {s_q[N:0], 1'b0};
    r_sum = r_q + m_ext;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          m_d     = M;
          u_d     = M;
          v_d     = X;
          r_d     = '0;
          s_d     = (N+2)'(1);
          k_d     = '0;
          sh_d    = (shift > SH_MAX) ? SH_MAX : shift;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        // u holds M and v holds X at this point
        if (abort) begin
          state_d = S_IDLE;
        end else if (!u_q[0] || (u_q == N'(1)) || (v_q == '0) || (v_q >= u_q)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_LOOP1;
        end
      end
      S_LOOP1: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (v_q == '0) begin
          state_d = S_FIX;
        end else begin
          k_d = k_q + SW'(1);
          if (!u_q[0]) begin
            u_d = u_q >> 1;
            s_d = s_dbl;
          end else if (!v_q[0]) begin
            v_d = v_q >> 1;
            r_d = r_dbl;
          end else if (u_q > v_q) begin
            u_d = (u_q - v_q) >> 1;
            r_d = r_q + s_q;
            s_d = s_dbl;
          end else begin
            v_d = (v_q - u_q) >> 1;
            s_d = s_q + r_q;
            r_d = r_dbl;
          end
        end
      end
      S_FIX: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (u_q != N'(1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          r_d     = m_ext - r_red;
          state_d = S_LOOP2;
        end
      end
      S_LOOP2: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (k_q > sh_q) begin
          // M is odd, so r+M is even whenever r is odd
          r_d = r_q[0] ? (r_sum >> 1) : (r_q >> 1);
          k_d = k_q - SW'(1);
        end else if (k_q < sh_q) begin
          r_d = (r_dbl >= m_ext) ? (r_dbl - m_ext) : r_dbl;
          k_d = k_q + SW'(1);
        end else begin
          res_d   = r_q[N-1:0];
          err_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_CHECK) || (state_q == S_LOOP1) ||
                     (state_q == S_FIX)   || (state_q == S_LOOP2);
  assign res_valid = (state_q == S_DONE);
  assign R         = res_q;
  assign err       = err_q;

endmodule

// File: tb/tb_inv_kaliski_shift.sv
module tb_inv_kaliski_shift;

  localparam int N8  = 8;
  localparam int SW8 = $clog2(2*N8+1);
  localparam int NB  = 255;
  localparam int SWB = $clog2(2*NB+1);

  localparam logic [NB-1:0] P25519 = {{247{1'b1}}, 8'hED};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  logic [N8-1:0]  x8, m8, r8;
  logic [SW8-1:0] sh8;
  logic           rv8, rdy8, ab8, busy8, err8, vld8, rr8;

  logic [NB-1:0]  xb, mb, rb;
  logic [SWB-1:0] shb;
  logic           rvb, rdyb, abb, busyb, errb, vldb, rrb;

  inv_kaliski_shift #(.N(N8), .SW(SW8)) dut8 (
    .clk(clk), .rst(rst), .X(x8), .M(m8), .shift(sh8),
    .req_valid(rv8), .req_ready(rdy8), .abort(ab8), .busy(busy8),
    .R(r8), .err(err8), .res_valid(vld8), .res_ready(rr8)
  );

  inv_kaliski_shift #(.N(NB), .SW(SWB)) dutb (
    .clk(clk), .rst(rst), .X(xb), .M(mb), .shift(shb),
    .req_valid(rvb), .req_ready(rdyb), .abort(abb), .busy(busyb),
    .R(rb), .err(errb), .res_valid(vldb), .res_ready(rrb)
  );

  initial begin
    #1500000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog");
  end

  // Reference: err for non-invertible input, otherwise inverse by search times 2^SH mod M.
  function automatic void model8(input int x, input int m, input int sh,
                                 output int er, output int ee);
    int s;
    int y;
    s  = (sh > 2*N8) ? 2*N8 : sh;
    y  = -1;
    er = 0;
    ee = 1;
    if ((m % 2 == 0) || (m == 1) || (x == 0) || (x >= m)) return;
    for (int i = 1; i < m; i++) begin
      if ((x * i) % m == 1) begin
        y = i;
        break;
      end
    end
    if (y < 0) return;
    ee = 0;
    er = y;
    repeat (s) er = (er * 2) % m;
  endfunction

  function automatic bit early_reject(input int x, input int m);
    return (m % 2 == 0) || (m == 1) || (x == 0) || (x >= m);
  endfunction

  task automatic start8(input int x, input int m, input int sh);
    int t = 0;
    @(negedge clk);
    while (!rdy8 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!rdy8) begin
      n_chk++; n_err++;
      $display("FAIL start8_timeout req_ready=%0b expected 1", rdy8);
    end
    x8  = 8'(x);
    m8  = 8'(m);
    sh8 = SW8'(sh);
    rv8 = 1'b1;
    @(negedge clk);
    rv8 = 1'b0;
  endtask

  // cyc numbers clock cycles with the accept cycle as 1
  task automatic wait8(output int cyc);
    cyc = 2;
    while (!vld8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!vld8) begin
      n_chk++; n_err++;
      $display("FAIL wait8_timeout res_valid=%0b expected 1", vld8);
    end
  endtask

  task automatic ack8();
    rr8 = 1'b1;
    @(negedge clk);
    rr8 = 1'b0;
  endtask

  task automatic start_b(input logic [NB-1:0] x, input int sh);
    int t = 0;
    @(negedge clk);
    while (!rdyb && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!rdyb) begin
      n_chk++; n_err++;
      $display("FAIL startb_timeout req_ready=%0b expected 1", rdyb);
    end
    xb  = x;
    mb  = P25519;
    shb = SWB'(sh);
    rvb = 1'b1;
    @(negedge clk);
    rvb = 1'b0;
  endtask

  task automatic wait_b(output int cyc);
    cyc = 2;
    while (!vldb && cyc < 1200) begin
      @(negedge clk);
      cyc++;
    end
    if (!vldb) begin
      n_chk++; n_err++;
      $display("FAIL waitb_timeout res_valid=%0b expected 1", vldb);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    x8 = '0; m8 = '0; sh8 = '0; rv8 = 0; ab8 = 0; rr8 = 0;
    xb = '0; mb = '0; shb = '0; rvb = 0; abb = 0; rrb = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({rdy8, busy8, vld8, err8} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_ctl8 got rdy/busy/vld/err=%b expected 1000", {rdy8, busy8, vld8, err8});
    end
    n_chk++;
    if (r8 !== 8'h00) begin
      n_err++;
      $display("FAIL reset_r8 got %h expected 00", r8);
    end
    n_chk++;
    if ({rdyb, busyb, vldb, errb} !== 4'b1000 || rb !== '0) begin
      n_err++;
      $display("FAIL reset_b got rdy/busy/vld/err=%b R=%h expected 1000 R=0",
               {rdyb, busyb, vldb, errb}, rb);
    end
  endtask

  task automatic test_vectors();
    int tm[10]  = '{13, 13, 13, 9, 12, 13, 13, 13, 251, 13};
    int tx[10]  = '{ 5,  5,  5, 6,  5,  0, 13,  1, 250,  5};
    int tsh[10] = '{ 0,  8, 16, 0,  0,  0,  0,  0,   0, 31};
    int er, ee, cyc;
    for (int i = 0; i < 10; i++) begin
      model8(tx[i], tm[i], tsh[i], er, ee);
      start8(tx[i], tm[i], tsh[i]);
      wait8(cyc);
      n_chk++;
      if (r8 !== 8'(er) || err8 !== 1'(ee)) begin
        n_err++;
        $display("FAIL vec%0d X=%0d M=%0d SH=%0d got R=%0d err=%0b expected R=%0d err=%0d",
                 i, tx[i], tm[i], tsh[i], r8, err8, er, ee);
      end
      n_chk++;
      if (early_reject(tx[i], tm[i]) ? (cyc != 3) : (cyc > 4 + 4*N8)) begin
        n_err++;
        $display("FAIL vec%0d_latency got cycle %0d expected %s", i, cyc,
                 early_reject(tx[i], tm[i]) ? "3" : "<= 36");
      end
      ack8();
    end
  endtask

  task automatic test_random8();
    int x, m, sh, er, ee, cyc;
    for (int i = 0; i < 40; i++) begin
      m  = int'($urandom_range(1, 255));
      x  = (i % 4 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, m - 1));
      sh = int'($urandom_range(0, 31));
      model8(x, m, sh, er, ee);
      start8(x, m, sh);
      wait8(cyc);
      n_chk++;
      if (r8 !== 8'(er) || err8 !== 1'(ee) || cyc > 4 + 4*N8) begin
        n_err++;
        $display("FAIL rand8 X=%0d M=%0d SH=%0d got R=%0d err=%0b cyc=%0d expected R=%0d err=%0d cyc<=36",
                 x, m, sh, r8, err8, cyc, er, ee);
      end
      ack8();
    end
  endtask

  task automatic test_busy_timing();
    int er, ee, cyc;
    model8(5, 13, 0, er, ee);
    start8(5, 13, 0);
    n_chk++;
    if ({rdy8, busy8, vld8} !== 3'b010) begin
      n_err++;
      $display("FAIL busy_start got rdy/busy/vld=%b expected 010", {rdy8, busy8, vld8});
    end
    // a request while busy must be ignored
    x8 = 8'd1; m8 = 8'd3; rv8 = 1'b1;
    @(negedge clk);
    rv8 = 1'b0;
    wait8(cyc);
    n_chk++;
    if ({rdy8, busy8} !== 2'b00 || r8 !== 8'(er) || err8 !== 1'(ee)) begin
      n_err++;
      $display("FAIL busy_done got rdy/busy=%b R=%0d err=%0b expected 00 R=%0d err=%0d",
               {rdy8, busy8}, r8, err8, er, ee);
    end
    ack8();
    n_chk++;
    if ({rdy8, busy8, vld8} !== 3'b100) begin
      n_err++;
      $display("FAIL busy_idle got rdy/busy/vld=%b expected 100", {rdy8, busy8, vld8});
    end
  endtask

  task automatic test_hold_back_to_back();
    int er, ee, cyc;
    logic [7:0] cap_r;
    logic cap_e;
    model8(5, 13, 8, er, ee);
    start8(5, 13, 8);
    wait8(cyc);
    cap_r = r8;
    cap_e = err8;
    n_chk++;
    if (cap_r !== 8'(er) || cap_e !== 1'(ee)) begin
      n_err++;
      $display("FAIL hold_result got R=%0d err=%0b expected R=%0d err=%0d", cap_r, cap_e, er, ee);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_chk++;
      if (vld8 !== 1'b1 || r8 !== cap_r || err8 !== cap_e || rdy8 !== 1'b0) begin
        n_err++;
        $display("FAIL hold_cycle%0d got vld=%0b R=%0d err=%0b rdy=%0b expected 1 %0d %0b 0",
                 i, vld8, r8, err8, rdy8, cap_r, cap_e);
      end
    end
    rr8 = 1'b1;
    x8 = 8'd1; m8 = 8'd13; sh8 = '0; rv8 = 1'b1;
    @(negedge clk);
    rr8 = 1'b0;
    n_chk++;
    if ({vld8, rdy8} !== 2'b01) begin
      n_err++;
      $display("FAIL ack_idle got vld/rdy=%b expected 01", {vld8, rdy8});
    end
    @(negedge clk);
    rv8 = 1'b0;
    n_chk++;
    if ({busy8, rdy8} !== 2'b10) begin
      n_err++;
      $display("FAIL b2b_accept got busy/rdy=%b expected 10", {busy8, rdy8});
    end
    wait8(cyc);
    n_chk++;
    if (r8 !== 8'd1 || err8 !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_result got R=%0d err=%0b expected R=1 err=0", r8, err8);
    end
    ack8();
  endtask

  task automatic test_abort();
    int er, ee, cyc;
    bit saw_valid;
    start8(5, 13, 0);
    repeat (3) @(negedge clk);
    n_chk++;
    if ({busy8, vld8} !== 2'b10) begin
      n_err++;
      $display("FAIL abort_pre got busy/vld=%b expected 10", {busy8, vld8});
    end
    ab8 = 1'b1;
    @(negedge clk);
    ab8 = 1'b0;
    n_chk++;
    if ({rdy8, busy8, vld8} !== 3'b100) begin
      n_err++;
      $display("FAIL abort_idle got rdy/busy/vld=%b expected 100", {rdy8, busy8, vld8});
    end
    saw_valid = 0;
    repeat (10) begin
      @(negedge clk);
      if (vld8 !== 1'b0) saw_valid = 1;
    end
    n_chk++;
    if (saw_valid) begin
      n_err++;
      $display("FAIL abort_noresult got res_valid seen=1 expected 0");
    end
    // abort in DONE has no effect
    start8(5, 12, 0);
    wait8(cyc);
    ab8 = 1'b1;
    @(negedge clk);
    ab8 = 1'b0;
    n_chk++;
    if ({vld8, err8} !== 2'b11) begin
      n_err++;
      $display("FAIL abort_done got vld/err=%b expected 11", {vld8, err8});
    end
    ack8();
    model8(5, 13, 0, er, ee);
    start8(5, 13, 0);
    wait8(cyc);
    n_chk++;
    if (r8 !== 8'(er) || err8 !== 1'(ee)) begin
      n_err++;
      $display("FAIL abort_next got R=%0d err=%0b expected R=%0d err=%0d", r8, err8, er, ee);
    end
    ack8();
  endtask

  task automatic test_reset_mid();
    int er, ee, cyc;
    start8(5, 13, 16);
    repeat (12) @(negedge clk);
    n_chk++;
    if ({busy8, vld8} !== 2'b10) begin
      n_err++;
      $display("FAIL rstmid_pre got busy/vld=%b expected 10", {busy8, vld8});
    end
    rst = 1'b1;
    #2;
    n_chk++;
    if ({rdy8, busy8, vld8, err8} !== 4'b1000 || r8 !== 8'h00) begin
      n_err++;
      $display("FAIL rstmid_vals got rdy/busy/vld/err=%b R=%0d expected 1000 R=0",
               {rdy8, busy8, vld8, err8}, r8);
    end
    @(negedge clk);
    rst = 1'b0;
    model8(5, 13, 16, er, ee);
    start8(5, 13, 16);
    wait8(cyc);
    n_chk++;
    if (r8 !== 8'(er) || err8 !== 1'(ee)) begin
      n_err++;
      $display("FAIL rstmid_next got R=%0d err=%0b expected R=%0d err=%0d", r8, err8, er, ee);
    end
    ack8();
  endtask

  task automatic test_x25519();
    int sh_set[3] = '{0, 255, 510};
    logic [NB-1:0]   xs[10];
    logic [255:0]    tmp;
    logic [NB:0]     p;
    logic [2*NB-1:0] prod;
    int cyc;
    xs[0] = {{(NB-1){1'b0}}, 1'b1};
    xs[1] = P25519 - 1'b1;
    for (int i = 2; i < 10; i++) begin
      for (int w = 0; w < 8; w++) tmp[w*32 +: 32] = $urandom;
      xs[i] = tmp[NB-1:0] % P25519;
      if (xs[i] == '0) xs[i] = {{(NB-1){1'b0}}, 1'b1};
    end
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 3; j++) begin
        p = {{NB{1'b0}}, 1'b1};
        repeat (sh_set[j]) begin
          p = p << 1;
          if (p >= {1'b0, P25519}) p = p - {1'b0, P25519};
        end
        start_b(xs[i], sh_set[j]);
        wait_b(cyc);
        prod = ({{NB{1'b0}}, rb} * {{NB{1'b0}}, xs[i]}) % {{NB{1'b0}}, P25519};
        n_chk++;
        if (errb !== 1'b0 || rb >= P25519 || prod !== {{(NB-1){1'b0}}, p} || cyc > 4 + 4*NB) begin
          n_err++;
          $display("FAIL x25519 i=%0d SH=%0d got R=%h err=%0b R*X=%h cyc=%0d expected err=0 R*X=%h cyc<=1024",
                   i, sh_set[j], rb, errb, prod[NB-1:0], cyc, p[NB-1:0]);
        end
        rrb = 1'b1;
        @(negedge clk);
        rrb = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random8();
    test_busy_timing();
    test_hold_back_to_back();
    test_abort();
    test_reset_mid();
    test_x25519();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
